// File: rtl/instq_dual_pkg.sv
// Shared types and constants for the dual-issue instruction queue
// and the dispatch / execution units that consume its slots.
package instq_dual_pkg;

    localparam int INST_W_DEF = 32;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    typedef struct packed {
        logic                  valid;
        logic [INST_W_DEF-1:0] inst;
    } disp_slot_t;

    function automatic logic [OPC_MSB-OPC_LSB:0] inst_opcode(
        input logic [INST_W_DEF-1:0] inst
    );
        return inst[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instq_dual_ptr_inc.sv
// Ring pointer advance by 0, 1 or 2 with natural power-of-two wrap.
// Shared with the reservation-station queues.
module instq_dual_ptr_inc #(
    parameter int PTR_W = 4
) (
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [1:0]       inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    assign ptr_o = ptr_i + PTR_W'(inc_i);

endmodule

// File: rtl/instq_dual.sv
// Dual-enqueue / dual-dequeue in-order instruction FIFO feeding
// the two dispatch slots, with flush and occupancy flags.
module instq_dual
    import instq_dual_pkg::*;
#(
    parameter int INST_W = INST_W_DEF,
    parameter int DEPTH  = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              enq_valid1,
    input  logic [INST_W-1:0] enq_inst1,
    input  logic              enq_valid2,
    input  logic [INST_W-1:0] enq_inst2,
    output logic              enq_ready,
    input  logic              stall1,
    input  logic              stall2,
    output logic [INST_W-1:0] inst1,
    output logic              valid1,
    output logic [INST_W-1:0] inst2,
    output logic              valid2,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [INST_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]  head_p1, tail_p1, head_nx, tail_nx;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop1, pop2, acc1, acc2;
    logic [1:0]        npop, npush;

    assign valid1    = count_q != '0;
    assign valid2    = count_q >= CNT_W'(2);
    assign inst1     = valid1 ? mem_q[head_q] : '0;
    assign inst2     = valid2 ? mem_q[head_p1] : '0;
    // Ready looks only at registered occupancy, never at same-cycle pops
    assign enq_ready = count_q <= CNT_W'(DEPTH - 2);
    assign full      = count_q == CNT_W'(DEPTH);
    assign empty     = count_q == '0;
    assign count     = count_q;

    assign pop1  = valid1 & ~stall1;
    assign pop2  = pop1 & valid2 & ~stall2;
    assign acc1  = enq_valid1 & enq_ready;
    assign acc2  = acc1 & enq_valid2;
    assign npop  = {1'b0, pop1} + {1'b0, pop2};
    assign npush = {1'b0, acc1} + {1'b0, acc2};

    instq_dual_ptr_inc #(.PTR_W(PTR_W)) u_head_p1 (
        .ptr_i(head_q), .inc_i(2'd1), .ptr_o(head_p1)
    );
    instq_dual_ptr_inc #(.PTR_W(PTR_W)) u_tail_p1 (
        .ptr_i(tail_q), .inc_i(2'd1), .ptr_o(tail_p1)
    );
    instq_dual_ptr_inc #(.PTR_W(PTR_W)) u_head_nx (
        .ptr_i(head_q), .inc_i(npop), .ptr_o(head_nx)
    );
    instq_dual_ptr_inc #(.PTR_W(PTR_W)) u_tail_nx (
        .ptr_i(tail_q), .inc_i(npush), .ptr_o(tail_nx)
    );

    always_comb begin
        head_d  = head_nx;
        tail_d  = tail_nx;
        count_d = count_q + CNT_W'(npush) - CNT_W'(npop);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc1 && !flush) mem_q[tail_q] <= enq_inst1;
        if (acc2 && !flush) mem_q[tail_p1] <= enq_inst2;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= CNT_W'(DEPTH));
            assert (tail_q == head_q + count_q[PTR_W-1:0]);
        end
    end

endmodule
